// File: rtl/clkmon_pkg.sv
// Shared types and helpers for the clock period monitor.
package clkmon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam int ERR_CNT_W = 8;

  // Counts up to max_v and then holds; callers cast to their own width (<= 32 bits).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/clock_period_monitor_sync.sv
// Synchronizer and edge detector for the monitored clock; emits a single-cycle edge pulse.
// CLKMON_GLITCH_FILTER_EN: an s2 level must hold for 2 cycles before it counts as an edge.
module sync_edge_detect (
  input  logic clock_in,
  input  logic reset,
  input  logic meas,
  output logic edge_p
);

  logic s1, s2, s3;

`ifdef CLKMON_GLITCH_FILTER_EN
  logic filt;

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      filt <= 1'b0;
    end else begin
      s1 <= meas;
      s2 <= s1;
      s3 <= s2;
      if (edge_p) filt <= s3;
    end
  end

  // filt tracks the last accepted level; a new level is accepted once s2 and s3 agree on it.
  assign edge_p = (s2 == s3) && (s3 != filt);
`else
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= meas;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_p = (s2 != s3);
`endif

endmodule

// File: rtl/clock_period_monitor.sv
// Measures the half-period of clock_meas in clock_in cycles and tracks lock / loss.
// Optional CLKMON_GLITCH_FILTER_EN rejects single-cycle glitches on the synchronized clock.
module clock_period_monitor
  import clkmon_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int EXPECT_HALF = 1,
  parameter int TOL         = 0,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 clock_meas,
  output logic [CNT_W-1:0]     half_period,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 timeout,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int LO_I = (EXPECT_HALF >= TOL) ? EXPECT_HALF - TOL : 0;
  localparam logic [CNT_W:0]     WIN_LO  = (CNT_W+1)'(LO_I);
  localparam logic [CNT_W:0]     WIN_HI  = (CNT_W+1)'(EXPECT_HALF + TOL);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [CNT_W-1:0]   TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [MC_W-1:0]    LOCK_N  = MC_W'(LOCK_COUNT);
  localparam logic [31:0]        ERR_MAX = 32'((64'd1 << ERR_CNT_W) - 64'd1);

  logic             edge_p;
  logic [CNT_W-1:0] cnt;
  state_t           state, state_nxt;
  logic [MC_W-1:0]  mcnt, mcnt_nxt, mcnt_inc;
  logic             publish, err_inc, in_win, to_hit;

  sync_edge_detect u_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .meas     (clock_meas),
    .edge_p   (edge_p)
  );

  // A saturated count means the real interval is unknown, so it never matches.
  assign in_win   = ({1'b0, cnt} >= WIN_LO) && ({1'b0, cnt} <= WIN_HI) && (cnt != CNT_MAX);
  assign to_hit   = !edge_p && (cnt == TO_VAL);
  assign mcnt_inc = mcnt + MC_W'(1);

  always_comb begin
    state_nxt = state;
    mcnt_nxt  = mcnt;
    publish   = 1'b0;
    err_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (edge_p) state_nxt = ACQUIRE;
        else if (to_hit) begin
          state_nxt = LOST;
          mcnt_nxt  = '0;
        end
      end
      ACQUIRE: begin
        if (edge_p) begin
          publish = 1'b1;
          if (in_win) begin
            mcnt_nxt = mcnt_inc;
            if (mcnt_inc == LOCK_N) state_nxt = LOCKED;
          end else begin
            mcnt_nxt = '0;
            err_inc  = 1'b1;
          end
        end else if (to_hit) begin
          state_nxt = LOST;
          mcnt_nxt  = '0;
        end
      end
      LOCKED: begin
        if (edge_p) begin
          publish = 1'b1;
          if (!in_win) begin
            state_nxt = ACQUIRE;
            mcnt_nxt  = '0;
            err_inc   = 1'b1;
          end
        end else if (to_hit) begin
          state_nxt = LOST;
          mcnt_nxt  = '0;
        end
      end
      LOST: begin
        // Interval ending at this edge spans the outage, so it is dropped.
        if (edge_p) state_nxt = ACQUIRE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      mcnt         <= '0;
      cnt          <= '0;
      half_period  <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      err_count    <= '0;
    end else begin
      state        <= state_nxt;
      mcnt         <= mcnt_nxt;
      cnt          <= edge_p ? CNT_W'(1) : CNT_W'(sat_inc(32'(cnt), 32'(CNT_MAX)));
      period_valid <= publish;
      locked       <= (state_nxt == LOCKED);
      timeout      <= (state_nxt == LOST);
      if (publish) half_period <= cnt;
      if (err_inc) err_count <= ERR_CNT_W'(sat_inc(32'(err_count), ERR_MAX));
    end
  end

endmodule

// File: tb/tb_clock_period_monitor.sv
// Directed bench for clock_period_monitor: default instance (A) and a windowed instance (B).
module tb_clock_period_monitor;

`ifdef CLKMON_GLITCH_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clock_in = 1'b0;
  logic reset = 1'b0;
  logic meas_a = 1'b0;
  logic meas_b = 1'b0;

  logic [15:0] hp_a, hp_b;
  logic        pv_a, pv_b, lk_a, lk_b, to_a, to_b;
  logic [7:0]  err_a, err_b;

  always #5 clock_in = ~clock_in;

  clock_period_monitor u_a (
    .clock_in     (clock_in),
    .reset        (reset),
    .clock_meas   (meas_a),
    .half_period  (hp_a),
    .period_valid (pv_a),
    .locked       (lk_a),
    .timeout      (to_a),
    .err_count    (err_a)
  );

  clock_period_monitor #(
    .CNT_W(16), .EXPECT_HALF(10), .TOL(1), .LOCK_COUNT(4), .TIMEOUT(20)
  ) u_b (
    .clock_in     (clock_in),
    .reset        (reset),
    .clock_meas   (meas_b),
    .half_period  (hp_b),
    .period_valid (pv_b),
    .locked       (lk_b),
    .timeout      (to_b),
    .err_count    (err_b)
  );

  int   n_tests = 0;
  int   n_fail = 0;
  int   pv_cnt_a = 0;
  int   pv_cnt_b = 0;
  int   pv_mark = 0;
  int   spent = 0;
  logic lk_at3 = 1'b0;
  logic lk_at4 = 1'b0;

  always @(negedge clock_in) begin
    if (pv_a) begin
      if (pv_cnt_a == 2) lk_at3 = lk_a;
      if (pv_cnt_a == 3) lk_at4 = lk_a;
      pv_cnt_a++;
    end
    if (pv_b) pv_cnt_b++;
  end

  typedef struct {
    int n;
    int pv;
    int hp;
    int lk;
    int to;
    int err;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic hold_toggle(input int n);
    repeat (n - spent) @(posedge clock_in);
    #1 meas_b = ~meas_b;
    spent = 0;
  endtask

  task automatic settle();
    repeat (LAT + 1) @(posedge clock_in);
    spent = LAT + 1;
    @(negedge clock_in);
    #1;
  endtask

  task automatic chk_b(input string tag, input int pv, input int hp, input int lk, input int to,
                       input int err);
    chk({tag, " pv"}, pv_cnt_b - pv_mark, pv);
    pv_mark = pv_cnt_b;
    chk({tag, " hp"}, int'(hp_b), hp);
    chk({tag, " locked"}, int'(lk_b), lk);
    chk({tag, " timeout"}, int'(to_b), to);
    chk({tag, " err"}, int'(err_b), err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{12, 0,  0, 0, 0, 0};
    tbl[1]  = '{ 9, 1,  9, 0, 0, 0};
    tbl[2]  = '{10, 1, 10, 0, 0, 0};
    tbl[3]  = '{11, 1, 11, 0, 0, 0};
    tbl[4]  = '{10, 1, 10, 1, 0, 0};
    tbl[5]  = '{13, 1, 13, 0, 0, 1};
    tbl[6]  = '{10, 1, 10, 0, 0, 1};
    tbl[7]  = '{10, 1, 10, 0, 0, 1};
    tbl[8]  = '{10, 1, 10, 0, 0, 1};
    tbl[9]  = '{10, 1, 10, 1, 0, 1};
    tbl[10] = '{ 8, 1,  8, 0, 0, 2};
    tbl[11] = '{12, 1, 12, 0, 0, 3};
    tbl[12] = '{ 9, 1,  9, 0, 0, 3};
    tbl[13] = '{11, 1, 11, 0, 0, 3};
    tbl[14] = '{20, 1, 20, 0, 0, 4};
    tbl[15] = '{ 9, 1,  9, 0, 0, 4};
    tbl[16] = '{11, 1, 11, 0, 0, 4};
    tbl[17] = '{10, 1, 10, 0, 0, 4};
    tbl[18] = '{ 9, 1,  9, 1, 0, 4};
    tbl[19] = '{21, 0,  9, 0, 0, 4};
    tbl[20] = '{10, 1, 10, 0, 0, 4};
    tbl[21] = '{10, 1, 10, 0, 0, 4};
    tbl[22] = '{10, 1, 10, 0, 0, 4};
    tbl[23] = '{10, 1, 10, 1, 0, 4};

    // Reset state
    repeat (3) @(posedge clock_in);
    #1;
    chk("rst hp_a", int'(hp_a), 0);
    chk("rst pv_a", int'(pv_a), 0);
    chk("rst lk_a", int'(lk_a), 0);
    chk("rst to_a", int'(to_a), 0);
    chk("rst err_a", int'(err_a), 0);
    chk("rst hp_b", int'(hp_b), 0);
    @(negedge clock_in);
    reset = 1'b1;

`ifndef CLKMON_GLITCH_FILTER_EN
    // Divide-by-2: one discarded edge, then four in-window edges lock.
    @(posedge clock_in);
    #1;
    for (int i = 0; i < 8; i++) begin
      meas_a = ~meas_a;
      @(posedge clock_in);
      #1;
    end
    repeat (LAT + 2) @(posedge clock_in);
    @(negedge clock_in);
    #1;
    chk("div2 pv count", pv_cnt_a, 7);
    chk("div2 hp", int'(hp_a), 1);
    chk("div2 err", int'(err_a), 0);
    chk("div2 locked", int'(lk_a), 1);
    chk("div2 locked@3", int'(lk_at3), 0);
    chk("div2 locked@4", int'(lk_at4), 1);
`endif

    // Window, recovery, exact-TIMEOUT measurement and timeout-then-edge
    for (int i = 0; i < 24; i++) begin
      hold_toggle(tbl[i].n);
      settle();
      chk_b($sformatf("row%0d", i), tbl[i].pv, tbl[i].hp, tbl[i].lk, tbl[i].to, tbl[i].err);
    end

    // Stopped clock from LOCKED: timeout on the edge after cnt reaches 20
    repeat (19) @(posedge clock_in);
    #1;
    chk("to before", int'(to_b), 0);
    chk("to before locked", int'(lk_b), 1);
    @(posedge clock_in);
    #1;
    chk("to rise", int'(to_b), 1);
    chk("to rise locked", int'(lk_b), 0);
    repeat (25 - (LAT + 21)) @(posedge clock_in);
    #1 meas_b = ~meas_b;
    spent = 0;
    settle();
    chk_b("to exit", 0, 10, 0, 0, 4);

    for (int j = 0; j < 4; j++) begin
      hold_toggle(10);
      settle();
      chk($sformatf("relock%0d locked", j), int'(lk_b), (j == 3) ? 1 : 0);
    end
    chk("relock hp", int'(hp_b), 10);

    // One-cycle glitch at +4 inside a 10-cycle half-period
    pv_mark = pv_cnt_b;
    hold_toggle(10);
    hold_toggle(4);
    hold_toggle(1);
    hold_toggle(5);
    settle();
`ifdef CLKMON_GLITCH_FILTER_EN
    chk_b("glitch", 2, 10, 1, 0, 4);
`else
    chk_b("glitch", 4, 5, 0, 0, 7);
`endif
    for (int j = 0; j < 4; j++) begin
      hold_toggle(10);
      settle();
    end
    pv_mark = pv_cnt_b;
    chk("pre-reset locked", int'(lk_b), 1);

    // Asynchronous reset mid-LOCKED, off the clock edge
    #2 reset = 1'b0;
    #1;
    chk("async lk_b", int'(lk_b), 0);
    chk("async hp_b", int'(hp_b), 0);
    chk("async err_b", int'(err_b), 0);
    chk("async pv_b", int'(pv_b), 0);
    chk("async to_b", int'(to_b), 0);
    chk("async err_a", int'(err_a), 0);
    meas_a = 1'b0;
    meas_b = 1'b0;
    @(negedge clock_in);
    reset = 1'b1;
    spent = 0;
    pv_mark = pv_cnt_b;
    hold_toggle(10);
    settle();
    chk_b("post-rst first", 0, 0, 0, 0, 0);
    hold_toggle(10);
    settle();
    chk_b("post-rst second", 1, 10, 0, 0, 0);

    // err_count saturation on A: 1 discarded + 300 out-of-window edges
    begin
      int base;
      base = pv_cnt_a;
      for (int i = 0; i < 301; i++) begin
        repeat (3) @(posedge clock_in);
        #1 meas_a = ~meas_a;
      end
      repeat (LAT + 2) @(posedge clock_in);
      @(negedge clock_in);
      #1;
      chk("sat pv count", pv_cnt_a - base, 300);
      chk("sat err", int'(err_a), 255);
      chk("sat hp", int'(hp_a), 3);
      chk("sat locked", int'(lk_a), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
